// File: rtl/coherence_bus_controller_pkg.sv
// Shared types and constants for the snoop-bus coherence controller.
package cache_config;

   localparam int DEFAULT_NUM_CORES = 4;
   localparam int CORE_ID_WIDTH     = $clog2(DEFAULT_NUM_CORES);

   // MESI bus transaction carried on the snoop bus
   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RDX  = 2'd1,
      BUS_UPGR = 2'd2,
      BUS_WB   = 2'd3
   } bus_op_t;

   // Direction of the L2 access that follows the snoop phase
   typedef enum logic [0:0] {
      L2_READ  = 1'b0,
      L2_WRITE = 1'b1
   } l2_op_t;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNOOP = 2'd1,
      MEM   = 2'd2,
      DONE  = 2'd3
   } cbc_state_t;

endpackage

// File: rtl/coherence_bus_controller_rr_arbiter.sv
// Round-robin arbiter: combinational search for the first request after ptr.
module rr_arbiter #(
   parameter int N = 4
)(
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);

   localparam int IW = $clog2(N);

   // Scan ptr+1, ptr+2, ... wrapping; the last slot checked is ptr itself
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (!valid && req[(int'(ptr) + i) % N]) begin
            valid                       = 1'b1;
            idx                         = IW'((int'(ptr) + i) % N);
            grant[(int'(ptr) + i) % N]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coherence_bus_controller.sv
// Snoop-bus sequencer: grants one core at a time, broadcasts the MESI
// transaction, gathers snoop responses and decides on the L2 access.
module coherence_bus_controller
   import cache_config::*;
#(
   parameter int NUM_CORES     = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int SNOOP_TIMEOUT = 16
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CORES-1:0]               req,
   input  logic [2*NUM_CORES-1:0]             req_op,
   input  logic [ADDRESS_WIDTH*NUM_CORES-1:0] req_addr,
   output logic [NUM_CORES-1:0]               gnt,
   output logic                               snoop_valid,
   output logic [1:0]                         snoop_op,
   output logic [ADDRESS_WIDTH-1:0]           snoop_addr,
   output logic [$clog2(NUM_CORES)-1:0]       snoop_src,
   input  logic [NUM_CORES-1:0]               snoop_ack,
   input  logic [NUM_CORES-1:0]               snoop_shared,
   input  logic [NUM_CORES-1:0]               snoop_dirty,
   output logic                               l2_req,
   output logic                               l2_op,
   output logic [ADDRESS_WIDTH-1:0]           l2_addr,
   input  logic                               l2_ready,
   output logic [NUM_CORES-1:0]               done,
   output logic                               done_shared,
   output logic                               snoop_err
);

   localparam int ID_W  = $clog2(NUM_CORES);
   localparam int TMR_W = $clog2(SNOOP_TIMEOUT);

   cbc_state_t               state;
   cbc_state_t               state_nxt;
   logic [ID_W-1:0]          ptr;
   logic [NUM_CORES-1:0]     ack_mask;
   logic [NUM_CORES-1:0]     shared_acc;
   logic [NUM_CORES-1:0]     dirty_acc;
   logic [TMR_W-1:0]         timer;

   logic [NUM_CORES-1:0]     arb_grant;
   logic [ID_W-1:0]          arb_idx;
   logic                     arb_valid;
   bus_op_t                  win_op;
   logic [ADDRESS_WIDTH-1:0] win_addr;

   logic [NUM_CORES-1:0]     src_mask;
   logic [NUM_CORES-1:0]     ack_now;
   logic [NUM_CORES-1:0]     shared_now;
   logic [NUM_CORES-1:0]     dirty_now;
   logic                     all_acked;
   logic                     timed_out;
   logic                     snoop_complete;
   logic                     flush_to_l2;

   rr_arbiter #(
      .N     (NUM_CORES)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Winner's request fields and this cycle's view of the snoop responses
   always_comb begin
      win_op         = bus_op_t'(req_op[int'(arb_idx)*2 +: 2]);
      win_addr       = req_addr[int'(arb_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      src_mask       = NUM_CORES'(1) << snoop_src;
      // the requester's own ack/shared/dirty lines are not part of the snoop
      ack_now        = (ack_mask | snoop_ack) & ~src_mask;
      shared_now     = shared_acc | (snoop_shared & snoop_ack & ~src_mask);
      dirty_now      = dirty_acc  | (snoop_dirty  & snoop_ack & ~src_mask);
      all_acked      = (ack_now == ~src_mask);
      timed_out      = (timer == TMR_W'(SNOOP_TIMEOUT - 1));
      snoop_complete = all_acked || timed_out;
      flush_to_l2    = (snoop_op == BUS_RD) && (dirty_now != '0);
   end

   // Next-state decision
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (arb_valid)
               state_nxt = (win_op == BUS_WB) ? MEM : SNOOP;
         end
         SNOOP: begin
            if (snoop_complete) begin
               if (snoop_op == BUS_UPGR)
                  state_nxt = DONE;
               else if (snoop_op == BUS_RDX && dirty_now != '0)
                  state_nxt = DONE;
               else
                  state_nxt = MEM;
            end
         end
         MEM: begin
            if (l2_ready)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Registered outputs, transaction latches, accumulators and snoop timer
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= ID_W'(NUM_CORES - 1);
         gnt         <= '0;
         snoop_valid <= 1'b0;
         snoop_op    <= '0;
         snoop_addr  <= '0;
         snoop_src   <= '0;
         l2_req      <= 1'b0;
         l2_op       <= 1'b0;
         l2_addr     <= '0;
         done        <= '0;
         done_shared <= 1'b0;
         snoop_err   <= 1'b0;
         ack_mask    <= '0;
         shared_acc  <= '0;
         dirty_acc   <= '0;
         timer       <= '0;
      end else begin
         done      <= '0;
         snoop_err <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  gnt         <= arb_grant;
                  snoop_src   <= arb_idx;
                  snoop_op    <= win_op;
                  snoop_addr  <= win_addr;
                  l2_addr     <= win_addr;
                  ack_mask    <= '0;
                  shared_acc  <= '0;
                  dirty_acc   <= '0;
                  timer       <= '0;
                  done_shared <= 1'b0;
                  if (win_op == BUS_WB) begin
                     // writeback needs no snoop: straight to L2
                     l2_req <= 1'b1;
                     l2_op  <= L2_WRITE;
                  end else begin
                     snoop_valid <= 1'b1;
                  end
               end
            end
            SNOOP: begin
               ack_mask   <= ack_now;
               shared_acc <= shared_now;
               dirty_acc  <= dirty_now;
               timer      <= timer + 1'b1;
               if (snoop_complete) begin
                  snoop_valid <= 1'b0;
                  // cores that never answered are treated as non-sharing
                  snoop_err   <= !all_acked;
                  if (state_nxt == DONE) begin
                     done        <= src_mask;
                     done_shared <= |shared_now;
                     gnt         <= '0;
                     ptr         <= snoop_src;
                  end else begin
                     l2_req <= 1'b1;
                     l2_op  <= flush_to_l2 ? L2_WRITE : L2_READ;
                  end
               end
            end
            MEM: begin
               if (l2_ready) begin
                  l2_req      <= 1'b0;
                  done        <= src_mask;
                  done_shared <= |shared_acc;
                  gnt         <= '0;
                  ptr         <= snoop_src;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
